pc_ctrl: RTL and testbench

Program-counter controller for the MIPS core: it holds the PC register, computes the next PC for sequential, jump, branch and register-jump flow, and takes interrupts. It also keeps an internal stack of exception return addresses, so interrupts can nest up to a configurable depth. It replaces the combinational next-PC stage plus the external single EPC register, and sits between the controller/decoder and instruction memory.

---
 rtl/pc_pkg.sv | 17 +
 rtl/epc_stack.sv | 62 ++++++
 rtl/pc_ctrl.sv | 124 ++++++++++++
 tb/tb_pc_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter controller.
//   npc_op_e      : encodings of the npc_op flow selector
//   RESET_VEC_DEF : default PC after reset
//   INT_VEC_DEF   : default interrupt entry address
package pc_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_JMP = 2'b01,
        NPC_BR  = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
    localparam logic [31:0] INT_VEC_DEF   = 32'h0000_3040;

endpackage

// File: rtl/epc_stack.sv
// LIFO of exception return addresses.
//   clk, rst_n : clock, async active-low reset (empties the stack)
//   push, din  : store din as the new top (ignored when full)
//   pop        : discard the top entry (ignored when empty)
//   top        : most recent entry, 0 when empty
//   depth      : number of stored entries (0..EPC_DEPTH)
//   full/empty : depth == EPC_DEPTH / depth == 0
module epc_stack #(
    parameter int unsigned AW        = 32,
    parameter int unsigned EPC_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                din,
    output logic [AW-1:0]                top,
    output logic [$clog2(EPC_DEPTH):0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = $clog2(EPC_DEPTH);
    localparam int unsigned DW = PW + 1;

    logic [AW-1:0] mem_q [EPC_DEPTH];
    logic [DW-1:0] depth_q;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          do_push;
    logic          do_pop;

    // The depth counter doubles as the write pointer; it only wraps to the
    // MSB when full, and no write happens then.
    assign wr_idx  = depth_q[PW-1:0];
    assign rd_idx  = wr_idx - PW'(1);
    assign full    = (depth_q == DW'(EPC_DEPTH));
    assign empty   = (depth_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;

    assign top   = empty ? '0 : mem_q[rd_idx];
    assign depth = depth_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else if (do_push) begin
            depth_q <= depth_q + DW'(1);
        end else if (do_pop) begin
            depth_q <= depth_q - DW'(1);
        end
    end

    // Contents need no reset; depth alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: PC register, next-PC selection for
// sequential/jump/branch/jr flow, interrupt entry and nested ERET return.
//   clk, rst_n  : clock, async active-low reset
//   stall       : hold PC, no stack activity
//   npc_op      : flow select (see pc_pkg::npc_op_e)
//   br_taken    : branch condition for NPC_BR
//   imm         : instruction immediate, imm[15:0] is the branch offset
//   reg_data    : jr target
//   intreq      : level interrupt request
//   eret        : ERET in current instruction
//   pc, pc_4    : current PC and PC + 4
//   npc         : next PC (combinational)
//   int_ack     : interrupt accepted this cycle
//   epc_top     : top return address (0 when empty)
//   epc_depth   : stacked return addresses
//   eret_err    : sticky, ERET seen with an empty stack
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned    AW        = 32,
    parameter logic [AW-1:0]  RESET_VEC = AW'(RESET_VEC_DEF),
    parameter logic [AW-1:0]  INT_VEC   = AW'(INT_VEC_DEF),
    parameter int unsigned    EPC_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic [1:0]                 npc_op,
    input  logic                       br_taken,
    input  logic [25:0]                imm,
    input  logic [AW-1:0]              reg_data,
    input  logic                       intreq,
    input  logic                       eret,
    output logic [AW-1:0]              pc,
    output logic [AW-1:0]              pc_4,
    output logic [AW-1:0]              npc,
    output logic                       int_ack,
    output logic [AW-1:0]              epc_top,
    output logic [$clog2(EPC_DEPTH):0] epc_depth,
    output logic                       eret_err
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] tgt;
    logic [AW-1:0] br_off;
    logic          eret_err_q;
    logic          eret_err_set;
    logic          stk_push;
    logic          stk_pop;
    logic          stk_full;
    logic          stk_empty;

    assign pc_4   = pc_q + AW'(4);
    assign br_off = {{(AW-18){imm[15]}}, imm[15:0], 2'b00};

    always_comb begin
        tgt = pc_4;
        unique case (npc_op_e'(npc_op))
            NPC_SEQ: tgt = pc_4;
            NPC_JMP: tgt = {pc_4[AW-1:28], imm, 2'b00};
            NPC_BR:  tgt = br_taken ? (pc_4 + br_off) : pc_4;
            NPC_JR:  tgt = reg_data;
            default: tgt = pc_4;
        endcase
    end

    // Interrupt beats ERET; a full stack makes the request invisible so the
    // current instruction's own flow (including ERET) proceeds.
    always_comb begin
        npc          = pc_q;
        int_ack      = 1'b0;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        eret_err_set = 1'b0;
        if (!stall) begin
            if (intreq && !stk_full) begin
                npc      = INT_VEC;
                int_ack  = 1'b1;
                stk_push = 1'b1;
            end else if (eret) begin
                if (!stk_empty) begin
                    npc     = epc_top;
                    stk_pop = 1'b1;
                end else begin
                    npc          = pc_4;
                    eret_err_set = 1'b1;
                end
            end else begin
                npc = tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VEC;
            eret_err_q <= 1'b0;
        end else begin
            pc_q <= npc;
            if (eret_err_set) begin
                eret_err_q <= 1'b1;
            end
        end
    end

    assign pc       = pc_q;
    assign eret_err = eret_err_q;

    epc_stack #(
        .AW        (AW),
        .EPC_DEPTH (EPC_DEPTH)
    ) u_epc_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (tgt),
        .top   (epc_top),
        .depth (epc_depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

    localparam logic [31:0] RST_V = 32'h0000_3000;
    localparam logic [31:0] INT_V = 32'h0000_3040;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic        br_taken = 1'b0;
    logic [25:0] imm = '0;
    logic [31:0] reg_data = '0;
    logic        intreq = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [31:0] npc;
    logic        int_ack;
    logic [31:0] epc_top;
    logic [2:0]  epc_depth;
    logic        eret_err;

    int n_vec = 0;
    int n_miss = 0;

    // Reference state
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    logic        m_err;

    always #5 clk = ~clk;

    pc_ctrl #(
        .AW        (32),
        .RESET_VEC (RST_V),
        .INT_VEC   (INT_V),
        .EPC_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .npc_op    (npc_op),
        .br_taken  (br_taken),
        .imm       (imm),
        .reg_data  (reg_data),
        .intreq    (intreq),
        .eret      (eret),
        .pc        (pc),
        .pc_4      (pc_4),
        .npc       (npc),
        .int_ack   (int_ack),
        .epc_top   (epc_top),
        .epc_depth (epc_depth),
        .eret_err  (eret_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] op, input logic br,
                         input logic [25:0] im, input logic [31:0] rd,
                         input logic ir, input logic er);
        stall = st; npc_op = op; br_taken = br; imm = im; reg_data = rd;
        intreq = ir; eret = er;
    endtask

    // One cycle: drive at posedge+1, compare against the model, advance.
    task automatic step(input logic st, input logic [1:0] op, input logic br,
                        input logic [25:0] im, input logic [31:0] rd,
                        input logic ir, input logic er);
        logic [31:0] seq, tgt, e_npc, e_top;
        logic        e_ack;
        int          off;
        drive(st, op, br, im, rd, ir, er);
        #2;
        seq = m_pc + 32'd4;
        off = int'($signed(im[15:0])) * 4;
        case (op)
            2'd0: tgt = seq;
            2'd1: tgt = (seq & 32'hF000_0000) | ({6'd0, im} * 32'd4);
            2'd2: tgt = br ? seq + 32'(off) : seq;
            default: tgt = rd;
        endcase
        e_top = (m_stk.size() == 0) ? 32'd0 : m_stk[$];
        chk("pc", pc, m_pc);
        chk("pc_4", pc_4, seq);
        chk("epc_top", epc_top, e_top);
        chk("epc_depth", 32'(epc_depth), m_stk.size());
        chk("eret_err", 32'(eret_err), 32'(m_err));
        e_ack = 1'b0;
        if (st) begin
            e_npc = m_pc;
        end else if (ir && m_stk.size() < DEPTH) begin
            e_npc = INT_V;
            e_ack = 1'b1;
            m_stk.push_back(tgt);
        end else if (er) begin
            if (m_stk.size() > 0) begin
                e_npc = m_stk.pop_back();
            end else begin
                e_npc = seq;
                m_err = 1'b1;
            end
        end else begin
            e_npc = tgt;
        end
        chk("npc", npc, e_npc);
        chk("int_ack", 32'(int_ack), 32'(e_ack));
        m_pc = e_npc;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; leaves rst_n released at posedge+1 with pc still RST_V.
    task automatic do_reset();
        drive(1'b0, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, RST_V);
        chk("rst_depth", 32'(epc_depth), 32'd0);
        chk("rst_top", epc_top, 32'd0);
        chk("rst_ack", 32'(int_ack), 32'd0);
        chk("rst_err", 32'(eret_err), 32'd0);
        m_pc = RST_V;
        m_stk.delete();
        m_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        br;
        logic [25:0] im;
        logic        ir;
        logic        er;
        logic [31:0] e_pc;
        logic [31:0] e_npc;
        logic        e_ack;
        int          e_depth;
        logic [31:0] e_top;
    } vec_t;

    vec_t tbl[13];
    logic [31:0] ret_exp[4];

    initial begin
        tbl[0]  = '{2'd0, 1'b0, 26'h0,    1'b0, 1'b0, 32'h3000, 32'h3004, 1'b0, 0, 32'h0};
        tbl[1]  = '{2'd0, 1'b0, 26'h0,    1'b0, 1'b0, 32'h3004, 32'h3008, 1'b0, 0, 32'h0};
        tbl[2]  = '{2'd0, 1'b0, 26'h0,    1'b0, 1'b0, 32'h3008, 32'h300C, 1'b0, 0, 32'h0};
        tbl[3]  = '{2'd0, 1'b0, 26'h0,    1'b0, 1'b0, 32'h300C, 32'h3010, 1'b0, 0, 32'h0};
        tbl[4]  = '{2'd2, 1'b1, 26'hFFFE, 1'b0, 1'b0, 32'h3010, 32'h300C, 1'b0, 0, 32'h0};
        tbl[5]  = '{2'd0, 1'b0, 26'h0,    1'b0, 1'b0, 32'h300C, 32'h3010, 1'b0, 0, 32'h0};
        tbl[6]  = '{2'd2, 1'b0, 26'hFFFE, 1'b0, 1'b0, 32'h3010, 32'h3014, 1'b0, 0, 32'h0};
        tbl[7]  = '{2'd0, 1'b0, 26'h0,    1'b0, 1'b0, 32'h3014, 32'h3018, 1'b0, 0, 32'h0};
        tbl[8]  = '{2'd0, 1'b0, 26'h0,    1'b0, 1'b0, 32'h3018, 32'h301C, 1'b0, 0, 32'h0};
        tbl[9]  = '{2'd0, 1'b0, 26'h0,    1'b0, 1'b0, 32'h301C, 32'h3020, 1'b0, 0, 32'h0};
        tbl[10] = '{2'd0, 1'b0, 26'h0,    1'b1, 1'b0, 32'h3020, 32'h3040, 1'b1, 0, 32'h0};
        tbl[11] = '{2'd0, 1'b0, 26'h0,    1'b0, 1'b1, 32'h3040, 32'h3024, 1'b0, 1, 32'h3024};
        tbl[12] = '{2'd0, 1'b0, 26'h0,    1'b0, 1'b0, 32'h3024, 32'h3028, 1'b0, 0, 32'h0};

        @(posedge clk);
        #1;
        do_reset();

        // Directed table
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, tbl[i].op, tbl[i].br, tbl[i].im, 32'h0, tbl[i].ir, tbl[i].er);
            #1;
            chk("tbl_pc", pc, tbl[i].e_pc);
            chk("tbl_npc", npc, tbl[i].e_npc);
            chk("tbl_ack", 32'(int_ack), 32'(tbl[i].e_ack));
            chk("tbl_depth", 32'(epc_depth), tbl[i].e_depth);
            chk("tbl_top", epc_top, tbl[i].e_top);
            step(1'b0, tbl[i].op, tbl[i].br, tbl[i].im, 32'h0, tbl[i].ir, tbl[i].er);
        end

        // Nest to full with distinct return addresses (jr targets get pushed)
        for (int i = 0; i < DEPTH; i++) begin
            ret_exp[i] = 32'h5000 + 32'(i) * 32'h100;
            step(1'b0, 2'd3, 1'b0, '0, ret_exp[i], 1'b1, 1'b0);
        end
        chk("nest_depth", 32'(epc_depth), DEPTH);
        // Fifth request is refused, flow continues
        step(1'b0, 2'd0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("full_no_ack_pc", pc, INT_V + 32'd4);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chk("pop_order", epc_top, ret_exp[i]);
            step(1'b0, 2'd0, 1'b0, '0, '0, 1'b0, 1'b1);
            chk("pop_pc", pc, ret_exp[i]);
        end

        // ERET with empty stack at 0x3100
        step(1'b0, 2'd3, 1'b0, '0, 32'h3100, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("eret_empty_pc", pc, 32'h3104);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
            chk("eret_err_sticky", 32'(eret_err), 32'd1);
        end

        // Stall with pending interrupt
        step(1'b1, 2'd0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 2'd0, 1'b0, '0, '0, 1'b1, 1'b1);
        chk("stall_hold", pc, 32'h3110);
        step(1'b0, 2'd0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("unstall_accept", pc, INT_V);

        // intreq and eret together: push, no pop
        step(1'b0, 2'd0, 1'b0, '0, '0, 1'b1, 1'b1);
        chk("int_eret_depth", 32'(epc_depth), 32'd2);

        // Reset mid-nest
        do_reset();

        // Randomized phase against the model
        for (int i = 0; i < 600; i++) begin
            if (i % 200 == 199) begin
                do_reset();
            end
            step(($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 26'($urandom), $urandom,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
